// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and constants for the data-memory arbiter.
package dmem_pkg;
    typedef enum logic {ARB_CPU, ARB_FORCE} arb_state_t;
    localparam logic [1:0]  AC_BYTE     = 2'b00;
    localparam logic [1:0]  AC_HALF     = 2'b01;
    localparam logic [1:0]  AC_WORD     = 2'b10;
    localparam int          AC_ZEXT_BIT = 2;
    localparam logic [16:0] MEM_TOP     = 17'h1FFFF;
endpackage

// File: rtl/dmem_range_check.sv
// dmem_range_check: flags accesses outside the implemented memory or with an illegal size.
module dmem_range_check
    import dmem_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_BITS  = 17
) (
    input  logic [DATA_WIDTH-1:0] addr,
    input  logic [1:0]            ctrl,
    output logic                  fault
);
    localparam logic [ADDR_BITS:0] HALF_EXT = (ADDR_BITS+1)'(1);
    localparam logic [ADDR_BITS:0] WORD_EXT = (ADDR_BITS+1)'(3);
    logic [ADDR_BITS:0] last;
    // The carry out of the last-byte address means the access wraps past the top.
    always_comb begin
        last  = {1'b0, addr[ADDR_BITS-1:0]} + (ctrl == AC_BYTE ? '0 : ctrl == AC_HALF ? HALF_EXT : WORD_EXT);
        fault = (|addr[DATA_WIDTH-1:ADDR_BITS]) | (ctrl == 2'b11) | last[ADDR_BITS];
    end
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares data_mem between the CPU MEM stage (priority) and the loader,
// with a bounded starvation counter that forces an occasional loader grant.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_BITS    = 17,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [DATA_WIDTH-1:0] cpu_addr,
    input  logic [2:0]            cpu_ctrl,
    input  logic [DATA_WIDTH-1:0] cpu_wd,
    output logic [DATA_WIDTH-1:0] cpu_rd,
    output logic                  cpu_stall,
    input  logic                  ld_valid,
    output logic                  ld_ready,
    input  logic                  ld_we,
    input  logic [DATA_WIDTH-1:0] ld_addr,
    input  logic [2:0]            ld_ctrl,
    input  logic [DATA_WIDTH-1:0] ld_wd,
    output logic [DATA_WIDTH-1:0] ld_rd,
    output logic                  ld_rd_valid,
    output logic                  ld_err,
    output logic [DATA_WIDTH-1:0] mem_a,
    output logic                  mem_we,
    output logic [2:0]            mem_ctrl,
    output logic [DATA_WIDTH-1:0] mem_wd,
    input  logic [DATA_WIDTH-1:0] mem_rd
);
    localparam int CW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    arb_state_t            state_q, state_d;
    logic [CW-1:0]         starve_cnt_q, starve_cnt_d;
    logic [DATA_WIDTH-1:0] ld_rd_q, ld_rd_d;
    logic                  ld_rd_valid_q, ld_rd_valid_d;
    logic                  ld_err_q, ld_err_d;
    logic                  cpu_grant, ld_grant, ld_acc, ld_fault;

    dmem_range_check #(.DATA_WIDTH(DATA_WIDTH), .ADDR_BITS(ADDR_BITS)) u_range (
        .addr  (ld_addr),
        .ctrl  (ld_ctrl[1:0]),
        .fault (ld_fault)
    );

    always_comb begin
        ld_grant      = ld_valid & ((state_q == ARB_FORCE) | ~cpu_req);
        cpu_grant     = cpu_req & ~ld_grant;
        ld_acc        = rst_n & ld_grant;
        ld_ready      = ld_acc;
        cpu_stall     = rst_n & cpu_req & ~cpu_grant;
        cpu_rd        = mem_rd;
        mem_a         = ld_grant ? ld_addr : cpu_addr;
        mem_ctrl      = ld_grant ? ld_ctrl : cpu_ctrl;
        mem_wd        = ld_grant ? ld_wd : cpu_wd;
        mem_we        = rst_n & (ld_grant ? ld_we & ~ld_fault : cpu_grant & cpu_we);
        starve_cnt_d  = (state_q == ARB_FORCE || !ld_valid || ld_grant) ? '0 :
                        (starve_cnt_q == LIMIT) ? starve_cnt_q : starve_cnt_q + 1'b1;
        state_d       = (state_q == ARB_CPU && starve_cnt_d == LIMIT) ? ARB_FORCE : ARB_CPU;
        ld_rd_valid_d = ld_acc & ~ld_we & ~ld_fault;
        ld_err_d      = ld_acc & ld_fault;
        ld_rd_d       = ld_rd_valid_d ? mem_rd : ld_rd_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ARB_CPU;
            starve_cnt_q  <= '0;
            ld_rd_q       <= '0;
            ld_rd_valid_q <= 1'b0;
            ld_err_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            starve_cnt_q  <= starve_cnt_d;
            ld_rd_q       <= ld_rd_d;
            ld_rd_valid_q <= ld_rd_valid_d;
            ld_err_q      <= ld_err_d;
        end
    end

    assign ld_rd       = ld_rd_q;
    assign ld_rd_valid = ld_rd_valid_q;
    assign ld_err      = ld_err_q;
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: scoreboard bench for dmem_arbiter with a behavioural data_mem.
module tb_dmem_arbiter;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        cpu_req, cpu_we, ld_valid, ld_we;
    logic [31:0] cpu_addr, cpu_wd, ld_addr, ld_wd;
    logic [2:0]  cpu_ctrl, ld_ctrl;
    logic [31:0] cpu_rd, ld_rd, mem_a, mem_wd, mem_rd;
    logic        cpu_stall, ld_ready, ld_rd_valid, ld_err, mem_we;
    logic [2:0]  mem_ctrl;

    typedef struct {
        logic        err;
        logic [31:0] data;
        int          due;
    } exp_t;

    exp_t        sb[$];
    exp_t        e;
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic [7:0]  mem [0:131071];

    dmem_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_ctrl(cpu_ctrl),
        .cpu_wd(cpu_wd), .cpu_rd(cpu_rd), .cpu_stall(cpu_stall),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_we(ld_we), .ld_addr(ld_addr),
        .ld_ctrl(ld_ctrl), .ld_wd(ld_wd), .ld_rd(ld_rd), .ld_rd_valid(ld_rd_valid),
        .ld_err(ld_err), .mem_a(mem_a), .mem_we(mem_we), .mem_ctrl(mem_ctrl),
        .mem_wd(mem_wd), .mem_rd(mem_rd)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural data_mem: combinational read, write at the rising edge.
    always @(*) begin
        logic [16:0] a;
        a = mem_a[16:0];
        case (mem_ctrl[1:0])
            2'b00:   mem_rd = {{24{~mem_ctrl[2] & mem[a][7]}}, mem[a]};
            2'b01:   mem_rd = {{16{~mem_ctrl[2] & mem[a+17'd1][7]}}, mem[a+17'd1], mem[a]};
            default: mem_rd = {mem[a+17'd3], mem[a+17'd2], mem[a+17'd1], mem[a]};
        endcase
    end

    always @(posedge clk) begin
        if (mem_we) begin
            mem[mem_a[16:0]] <= mem_wd[7:0];
            if (mem_ctrl[1:0] != 2'b00) mem[mem_a[16:0]+17'd1] <= mem_wd[15:8];
            if (mem_ctrl[1:0] == 2'b10) begin
                mem[mem_a[16:0]+17'd2] <= mem_wd[23:16];
                mem[mem_a[16:0]+17'd3] <= mem_wd[31:24];
            end
        end
    end

    // Scoreboard: each loader response must match the oldest expectation, in its due cycle.
    always @(negedge clk) begin
        if (ld_rd_valid || ld_err) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL ld_unexpected: got rd_valid=%0b err=%0b rd=%h, required no response", ld_rd_valid, ld_err, ld_rd);
            end else begin
                e = sb.pop_front();
                if ({ld_err, ld_rd_valid} !== {e.err, ~e.err} || cyc != e.due || (!e.err && ld_rd !== e.data)) begin
                    errors++;
                    $display("FAIL ld_resp: got err=%0b rd_valid=%0b rd=%h cycle=%0d, required err=%0b rd=%h cycle=%0d",
                             ld_err, ld_rd_valid, ld_rd, cyc, e.err, e.data, e.due);
                end
            end
        end else if (sb.size() > 0 && sb[0].due <= cyc) begin
            checks++;
            errors++;
            $display("FAIL ld_missing: got no response in cycle %0d, required err=%0b rd=%h", cyc, sb[0].err, sb[0].data);
            void'(sb.pop_front());
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic ld_req(input logic we, input logic [31:0] a, input logic [2:0] c, input logic [31:0] wd);
        ld_valid = 1'b1;
        ld_we    = we;
        ld_addr  = a;
        ld_ctrl  = c;
        ld_wd    = wd;
    endtask

    task automatic expect_accept(input string name, input logic err, input logic [31:0] data, input logic we_exp);
        @(negedge clk);
        checks++;
        if (ld_ready !== 1'b1 || mem_we !== we_exp) begin
            errors++;
            $display("FAIL %s_accept: got ld_ready=%0b mem_we=%0b, required ld_ready=1 mem_we=%0b", name, ld_ready, mem_we, we_exp);
        end
        if (!we_exp || err) sb.push_back('{err: err, data: data, due: cyc + 1});
        next_cycle();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h100; cpu_ctrl = 3'b010; cpu_wd = 32'h1111_1111;
        ld_req(1'b1, 32'h10000, 3'b010, 32'h2222_2222);
        @(negedge clk);
        checks++;
        if (mem_we !== 1'b0 || ld_ready !== 1'b0 || ld_rd_valid !== 1'b0 || cpu_stall !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: got mem_we=%0b ld_ready=%0b ld_rd_valid=%0b cpu_stall=%0b, required all 0",
                     mem_we, ld_ready, ld_rd_valid, cpu_stall);
        end
        next_cycle();
        rst_n = 1'b1; cpu_we = 1'b0; ld_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (cpu_stall !== 1'b0 || mem_a !== 32'h100 || ld_ready !== 1'b0 || ld_rd !== 32'h0) begin
            errors++;
            $display("FAIL reset_cpu_grant: got cpu_stall=%0b mem_a=%h ld_rd=%h, required 0 00000100 00000000", cpu_stall, mem_a, ld_rd);
        end
        next_cycle();
        cpu_req = 1'b0;
    endtask

    task automatic test_write_read();
        ld_req(1'b1, 32'h10000, 3'b010, 32'hDEADBEEF);
        expect_accept("ld_write", 1'b0, 32'h0, 1'b1);
        ld_req(1'b0, 32'h10000, 3'b010, 32'h0);
        expect_accept("ld_read", 1'b0, 32'hDEADBEEF, 1'b0);
        ld_req(1'b0, 32'h10000, 3'b001, 32'h0);
        expect_accept("ld_read_half_sext", 1'b0, 32'hFFFFBEEF, 1'b0);
        ld_valid = 1'b0;
        next_cycle();
        next_cycle();
    endtask

    task automatic test_priority();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h200; cpu_ctrl = 3'b010;
        ld_req(1'b0, 32'h10000, 3'b010, 32'h0);
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            checks++;
            if (cpu_stall !== 1'b0 || ld_ready !== 1'b0 || mem_a !== 32'h200) begin
                errors++;
                $display("FAIL prio_cycle%0d: got cpu_stall=%0b ld_ready=%0b mem_a=%h, required 0 0 00000200", i, cpu_stall, ld_ready, mem_a);
            end
            next_cycle();
        end
        @(negedge clk);
        checks++;
        if (cpu_stall !== 1'b1 || ld_ready !== 1'b1 || mem_a !== 32'h10000) begin
            errors++;
            $display("FAIL prio_force: got cpu_stall=%0b ld_ready=%0b mem_a=%h, required 1 1 00010000", cpu_stall, ld_ready, mem_a);
        end
        sb.push_back('{err: 1'b0, data: 32'hDEADBEEF, due: cyc + 1});
        next_cycle();
        @(negedge clk);
        checks++;
        if (cpu_stall !== 1'b0 || ld_ready !== 1'b0 || mem_a !== 32'h200) begin
            errors++;
            $display("FAIL prio_after_force: got cpu_stall=%0b ld_ready=%0b mem_a=%h, required 0 0 00000200", cpu_stall, ld_ready, mem_a);
        end
        next_cycle();
        ld_valid = 1'b0; cpu_req = 1'b0;
        next_cycle();
    endtask

    task automatic test_interleave();
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h10004; cpu_ctrl = 3'b100; cpu_wd = 32'h1234565A;
        @(negedge clk);
        checks++;
        if (cpu_stall !== 1'b0 || mem_we !== 1'b1 || mem_a !== 32'h10004) begin
            errors++;
            $display("FAIL cpu_store: got cpu_stall=%0b mem_we=%0b mem_a=%h, required 0 1 00010004", cpu_stall, mem_we, mem_a);
        end
        next_cycle();
        cpu_req = 1'b0; cpu_we = 1'b0;
        next_cycle();
        ld_req(1'b0, 32'h10004, 3'b100, 32'h0);
        expect_accept("ld_lbu", 1'b0, 32'h0000005A, 1'b0);
        ld_valid = 1'b0;
        next_cycle();
    endtask

    task automatic test_boundaries();
        logic        we_t [5]   = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        logic [31:0] a_t  [5]   = '{32'h1FFFE, 32'h20000, 32'h10008, 32'h1FFFC, 32'h1FFFF};
        logic [2:0]  c_t  [5]   = '{3'b010, 3'b010, 3'b011, 3'b010, 3'b100};
        logic        err_t [5]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 5; i++) begin
            ld_req(we_t[i], a_t[i], c_t[i], 32'hCAFEF00D);
            expect_accept($sformatf("bound%0d", i), err_t[i], 32'h0, 1'b0);
            ld_valid = 1'b0;
            next_cycle();
        end
        next_cycle();
    endtask

    task automatic test_mid_reset();
        ld_req(1'b0, 32'h10000, 3'b010, 32'h0);
        @(negedge clk);
        checks++;
        if (ld_ready !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset_accept: got ld_ready=%0b, required 1", ld_ready);
        end
        next_cycle();
        rst_n = 1'b0; ld_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (ld_rd_valid !== 1'b0 || ld_rd !== 32'h0) begin
            errors++;
            $display("FAIL mid_reset_clear: got ld_rd_valid=%0b ld_rd=%h, required 0 00000000", ld_rd_valid, ld_rd);
        end
        next_cycle();
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (ld_rd_valid !== 1'b0 || ld_rd !== 32'h0) begin
            errors++;
            $display("FAIL mid_reset_reissue: got ld_rd_valid=%0b ld_rd=%h, required 0 00000000", ld_rd_valid, ld_rd);
        end
        next_cycle();
    endtask

    initial begin
        for (int i = 0; i < 131072; i++) mem[i] = 8'h00;
        test_reset();
        test_write_read();
        test_priority();
        test_interleave();
        test_boundaries();
        test_mid_reset();
        repeat (3) next_cycle();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending, required 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter that shares the single-ported data memory between the pipeline MEM stage (CPU port) and the program/data loader (LD port). The CPU port has priority; a bounded starvation counter guarantees the loader forward progress. The loader port also gets a range/format check. The block sits between the MEM stage, the loader and `data_mem`, and drives all `data_mem` inputs.

## Interface
- `DATA_WIDTH`, default 32: data and address width.
- `ADDR_BITS`, default 17: implemented memory address bits, covering 0x00000–0x1FFFF.
- `STARVE_LIMIT`, default 4: number of consecutive denied LD cycles before one LD grant is forced.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `cpu_req` in 1: MEM stage accesses memory this cycle (load or store).
- `cpu_we` in 1: CPU store.
- `cpu_addr` in 32: CPU byte address.
- `cpu_ctrl` in 3: CPU AddressingControl. Bit 2 is zero-extend; [1:0] are 00 byte, 01 half, 10 word.
- `cpu_wd` in 32: CPU store data.
- `cpu_rd` out 32: CPU load data, combinational from `mem_rd`.
- `cpu_stall` out 1: CPU denied this cycle; the pipeline holds the MEM stage.
- `ld_valid` in 1: loader request valid.
- `ld_ready` out 1: loader request accepted this cycle.
- `ld_we`, `ld_addr`[31:0], `ld_ctrl`[2:0], `ld_wd`[31:0] in: loader request fields, with the same meanings as the CPU fields.
- `ld_rd` out 32: registered loader read data.
- `ld_rd_valid` out 1: one-cycle pulse; `ld_rd` is valid.
- `ld_err` out 1: one-cycle pulse; the accepted LD request faulted and was dropped.
- `mem_a` out 32, `mem_we` out 1, `mem_ctrl` out 3, `mem_wd` out 32: drive `data_mem`.
- `mem_rd` in 32: `data_mem` RD, combinational.

## Operation
- **States:**
  - `ARB_CPU`: CPU priority.
  - `ARB_FORCE`: one-cycle forced LD grant.
- **Grant in `ARB_CPU`:**
  - `cpu_req=1` grants the CPU.
  - Otherwise, `ld_valid=1` grants LD.
- **Grant in `ARB_FORCE`:** LD is granted if `ld_valid=1`. If `ld_valid` has dropped, the CPU is granted.
- **Starvation counter `starve_cnt`:**
  - Increments each cycle that `ld_valid=1` and LD is not granted.
  - Clears on any LD grant and whenever `ld_valid=0`.
  - When the counter reaches `STARVE_LIMIT`, the next state is `ARB_FORCE`.
  - `ARB_FORCE` always returns to `ARB_CPU` after one cycle and clears the counter.
- **Status outputs:**
  - `cpu_stall = cpu_req & ~cpu_grant`.
  - `ld_ready = ld_valid & ld_grant`.
- **Memory mux:** the granted port's fields drive `mem_a/mem_ctrl/mem_wd`.
  - `mem_we` equals the granted port's write enable, gated to 0 on an LD fault.
  - With no grant, `mem_we=0` and the other memory outputs hold the CPU fields.
- **LD fault:** asserted when any of the following holds:
  - `ld_addr[31:ADDR_BITS] != 0`;
  - `ld_ctrl[1:0]==2'b11`;
  - the access runs past the top of memory: `ld_addr[ADDR_BITS-1:0] + size-1 > 2^ADDR_BITS-1`, where size is 1/2/4 bytes.
- **On a faulted accepted LD request:**
  - no memory write occurs;
  - `ld_err` pulses the next cycle;
  - `ld_rd_valid` stays 0.
- **LD read accepted without fault:** `mem_rd` is captured into `ld_rd` at the grant edge; `ld_rd_valid` pulses next cycle.
- **Counter width:** `$clog2(STARVE_LIMIT+1)`. The counter saturates and never wraps.

## Timing
- **Reset values:**
  - `state=ARB_CPU`, `starve_cnt=0`.
  - `ld_rd=0`, `ld_rd_valid=0`, `ld_err=0`.
  - While `rst_n=0`: `mem_we=0`, `ld_ready=0`, `cpu_stall=0`.
- **CPU access:** zero added latency. Grant and `cpu_rd` are combinational in the same cycle; stores commit at that cycle's rising edge in `data_mem`.
- **LD read:** accepted in cycle N; `ld_rd`/`ld_rd_valid` appear in N+1.
- **LD write:** commits at the edge ending cycle N.
- **LD throughput:** back-to-back LD accepts, one per cycle, while the CPU is idle.
- **Worst-case LD wait:** `STARVE_LIMIT` denied cycles, with the accept in cycle `STARVE_LIMIT+1`.
- **Worst-case CPU stall:** 1 cycle per `STARVE_LIMIT+1` cycles.
- **Handshake rule:** the loader holds all `ld_*` fields stable while `ld_valid=1 & ld_ready=0`.
- **Reset mid-operation:** an in-flight `ld_rd_valid`/`ld_err` is cleared and not re-issued.

## Structure
- **Package `dmem_pkg`:**
  - `arb_state_t` (`ARB_CPU`, `ARB_FORCE`);
  - access-size localparams `AC_BYTE=2'b00`, `AC_HALF=2'b01`, `AC_WORD=2'b10`;
  - `AC_ZEXT_BIT=2`;
  - `MEM_TOP=17'h1FFFF`.
- **Sub-module `dmem_range_check`:** combinational; inputs addr and ctrl, output fault. It is instantiated on the LD port.

## Test plan
- **Reset:** `rst_n` low with `ld_valid=1`, `cpu_req=1` → `mem_we=0`, `ld_ready=0`, `ld_rd_valid=0`. After release, the CPU is granted.
- **CPU priority:** `cpu_req=1` and `ld_valid=1` for 4 cycles → `cpu_stall=0`, `ld_ready=0`. In cycle 5 the LD grant is forced, with `cpu_stall=1` and `ld_ready=1`. In cycle 6 the CPU is granted again.
- **LD write then read:**
  - LD write word 0xDEADBEEF to 0x10000 with the CPU idle → write committed.
  - LD read of the same address → `ld_rd=0xDEADBEEF` with a `ld_rd_valid` pulse one cycle after accept.
- **CPU/LD interleave:** CPU `sb 0x5A` to 0x10004 and LD `lbu` of 0x10004 two cycles later → `ld_rd=0x0000005A`.
- **Fault cases:** each of the following gives `ld_ready=1`, no write, a `ld_err` pulse next cycle and `ld_rd_valid=0`:
  - LD word write to 0x1FFFE;
  - LD access to 0x20000;
  - `ld_ctrl=3'b011`.
- **Mid-operation reset:** `rst_n` asserted in the cycle after an LD read accept → `ld_rd_valid` stays 0 and `ld_rd=0`.
